// File: rtl/rom_arb.sv
// Round-robin arbiter sharing one single-port ROM read port among N requesters.
// Grants are combinational; responses return RL+1 cycles after the handshake, in grant order.
module rom_arb #(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int OUT_REG = 1,
    localparam int AW     = $clog2(DEPTH),
    localparam int IW     = $clog2(N)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N-1:0]      req_valid_i,
    input  logic [N*AW-1:0]   req_addr_i,
    output logic [N-1:0]      req_ready_o,
    output logic [N-1:0]      rsp_valid_o,
    output logic [IW-1:0]     rsp_id_o,
    output logic [WIDTH-1:0]  rsp_data_o,
    output logic              rom_rd_en_o,
    output logic [AW-1:0]     rom_rd_addr_o,
    input  logic [WIDTH-1:0]  rom_rd_data_i,
    output logic              busy_o
);

    logic [IW-1:0] ptr;
    logic          found;
    logic [IW-1:0] gnt_id;
    logic [IW-1:0] sel_id;
    logic          vld_p0;
    logic [IW-1:0] id_p0;
    logic          inflight;

    // Search from ptr upward, wrapping modulo N; first valid requester wins.
    always_comb begin
        int idx;
        found  = 1'b0;
        gnt_id = '0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_valid_i[IW'(idx)]) begin
                found  = 1'b1;
                gnt_id = IW'(idx);
            end
        end
    end

    assign sel_id        = found ? gnt_id : ptr;
    assign req_ready_o   = (found && !rst_i) ? (N'(1) << gnt_id) : '0;
    assign rom_rd_en_o   = found & ~rst_i;
    assign rom_rd_addr_o = req_addr_i[int'(sel_id)*AW +: AW];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gnt_id == IW'(N-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // ---- stage p0: in-flight tag aligned with ROM read data ----
    generate
        if (OUT_REG != 0) begin : g_reg
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    vld_p0 <= 1'b0;
                    id_p0  <= '0;
                end else begin
                    vld_p0 <= found;
                    id_p0  <= gnt_id;
                end
            end
            assign inflight = vld_p0;
        end else begin : g_comb
            assign vld_p0   = found & ~rst_i;
            assign id_p0    = gnt_id;
            assign inflight = 1'b0;
        end
    endgenerate

    // ---- stage p1: response register ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_o <= '0;
            rsp_id_o    <= '0;
            rsp_data_o  <= '0;
        end else if (vld_p0) begin
            rsp_valid_o <= N'(1) << id_p0;
            rsp_id_o    <= id_p0;
            rsp_data_o  <= rom_rd_data_i;
        end else begin
            rsp_valid_o <= '0;
        end
    end

    assign busy_o = inflight | (|rsp_valid_o);

endmodule

// File: tb/tb_rom_arb.sv
// Scoreboard bench for rom_arb: an OUT_REG=1 and an OUT_REG=0 instance share stimulus
// and are checked against a round-robin reference model with a per-instance response queue.
module tb_rom_arb;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AW = 3;

    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [N-1:0]  valid;
    logic [N*AW-1:0] addr;
    logic [N-1:0]  ready [2];
    logic [N-1:0]  rspv  [2];
    logic [1:0]    rid   [2];
    logic [W-1:0]  rdata [2];
    logic [W-1:0]  romd  [2];
    logic          en    [2];
    logic [AW-1:0] raddr [2];
    logic          busy  [2];

    logic [W-1:0]  rom [D];
    exp_t          q [2][$];
    int            ptr_m;
    int            cyc;
    int            total;
    int            bad;

    rom_arb #(.N(N), .WIDTH(W), .DEPTH(D), .OUT_REG(0)) u0 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_addr_i(addr),
        .req_ready_o(ready[0]), .rsp_valid_o(rspv[0]), .rsp_id_o(rid[0]),
        .rsp_data_o(rdata[0]), .rom_rd_en_o(en[0]), .rom_rd_addr_o(raddr[0]),
        .rom_rd_data_i(romd[0]), .busy_o(busy[0])
    );

    rom_arb #(.N(N), .WIDTH(W), .DEPTH(D), .OUT_REG(1)) u1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_addr_i(addr),
        .req_ready_o(ready[1]), .rsp_valid_o(rspv[1]), .rsp_id_o(rid[1]),
        .rsp_data_o(rdata[1]), .rom_rd_en_o(en[1]), .rom_rd_addr_o(raddr[1]),
        .rom_rd_data_i(romd[1]), .busy_o(busy[1])
    );

    // ROM models: combinational for OUT_REG=0, registered for OUT_REG=1.
    assign romd[0] = rom[raddr[0]];
    always @(posedge clk) begin
        if (en[1]) romd[1] <= rom[raddr[1]];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: reference arbitration plus scoreboard pop/compare.
    always @(negedge clk) begin
        int   g;
        int   idx;
        bit   bexp;
        exp_t e;
        if (rst) begin
            ptr_m = 0;
            for (int d = 0; d < 2; d++) begin
                q[d].delete();
                chk($sformatf("rst_ready%0d", d), int'(ready[d]), 0);
                chk($sformatf("rst_en%0d", d), int'(en[d]), 0);
                chk($sformatf("rst_rspv%0d", d), int'(rspv[d]), 0);
                chk($sformatf("rst_id%0d", d), int'(rid[d]), 0);
                chk($sformatf("rst_data%0d", d), int'(rdata[d]), 0);
                chk($sformatf("rst_busy%0d", d), int'(busy[d]), 0);
            end
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (ptr_m + k) % N;
                if (g < 0 && valid[idx]) g = idx;
            end
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("ready%0d", d), int'(ready[d]), (g >= 0) ? (1 << g) : 0);
                chk($sformatf("rd_en%0d", d), int'(en[d]), (g >= 0) ? 1 : 0);
                if (g >= 0)
                    chk($sformatf("rd_addr%0d", d), int'(raddr[d]), int'(addr[g*AW +: AW]));
                bexp = 1'b0;
                foreach (q[d][j]) if (q[d][j].due <= cyc + d) bexp = 1'b1;
                chk($sformatf("busy%0d", d), int'(busy[d]), int'(bexp));
                if (q[d].size() > 0 && q[d][0].due == cyc) begin
                    e = q[d].pop_front();
                    chk($sformatf("rsp_valid%0d", d), int'(rspv[d]), 1 << e.id);
                    chk($sformatf("rsp_id%0d", d), int'(rid[d]), e.id);
                    chk($sformatf("rsp_data%0d", d), int'(rdata[d]), int'(e.data));
                end else begin
                    chk($sformatf("rsp_idle%0d", d), int'(rspv[d]), 0);
                end
                if (g >= 0) begin
                    e.due  = cyc + 1 + d;
                    e.id   = g;
                    e.data = rom[addr[g*AW +: AW]];
                    q[d].push_back(e);
                end
            end
            if (g >= 0) ptr_m = (g + 1) % N;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        cyc   = 0;
        total = 0;
        bad   = 0;
        ptr_m = 0;
        rst   = 1'b1;
        valid = '0;
        addr  = '0;
        for (int i = 0; i < D; i++) rom[i] = W'($urandom);
        rom[5] = 8'hA5;
        step(3);
        rst = 1'b0;
        step(1);

        // Single request from requester 2 at address 5.
        valid = 4'b0100;
        addr[2*AW +: AW] = 3'd5;
        step(1);
        valid = '0;
        step(3);

        // Full contention from reset.
        pulse_reset();
        addr  = 12'($urandom);
        valid = 4'b1111;
        step(8);
        valid = '0;
        step(3);

        // Lone streaming requester 3, addresses 0..4.
        valid = 4'b1000;
        for (int a = 0; a < 5; a++) begin
            addr[3*AW +: AW] = AW'(a);
            step(1);
        end
        valid = '0;
        step(3);

        // Fairness after a grant to requester 1.
        valid = 4'b0010;
        step(1);
        valid = 4'b0011;
        step(2);
        valid = '0;
        step(3);

        // Reset one cycle after granting requester 1.
        valid = 4'b0010;
        step(1);
        valid = '0;
        rst   = 1'b1;
        step(2);
        rst   = 1'b0;
        step(3);
        valid = 4'b1111;
        step(1);
        valid = '0;
        step(3);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            valid = N'($urandom);
            addr  = 12'($urandom);
            rst   = ($urandom_range(0, 49) == 0);
            step(1);
        end
        rst   = 1'b0;
        valid = '0;
        step(4);
        chk("drain", q[0].size() + q[1].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rom_arb.md
# rom_arb

Round-robin arbiter that shares one single-port ROM read port among N requesters. Each requester issues an address through a valid/ready handshake; the arbiter grants at most one request per cycle, drives the ROM read port, and tracks in-flight reads through the ROM's read latency. It returns the data to the originating requester with a one-cycle response strobe. It sits between ROM-consuming engines (table lookups, coefficient fetch) and a single `rom_sp` instance.

## Interface
- `N`, 4: number of requesters; legal values are 2..16.
- `WIDTH`, 8: ROM data width; must match the ROM instance.
- `DEPTH`, 8: ROM depth; address width is `AW = $clog2(DEPTH)`.
- `OUT_REG`, 1: must match the ROM instance's `OUT_REG`. It sets ROM read latency `RL = OUT_REG` (0 or 1).

Ports:
- `clk_i` in 1: single clock, used for the arbiter and the ROM.
- `rst_i` in 1: asynchronous, active-high reset.
- `req_valid_i` in N: per-requester request valid.
- `req_addr_i` in N×AW: per-requester address; packed, with requester i at bits `[i*AW +: AW]`.
- `req_ready_o` out N: per-requester grant; one-hot or zero.
- `rsp_valid_o` out N: per-requester response strobe; one-hot or zero.
- `rsp_id_o` out $clog2(N): index of the requester being answered.
- `rsp_data_o` out WIDTH: response data, shared by all requesters.
- `rom_rd_en_o` out 1: ROM read enable.
- `rom_rd_addr_o` out AW: ROM read address.
- `rom_rd_data_i` in WIDTH: ROM read data.
- `busy_o` out 1: high while any read is in flight or a response is being presented.

## Operation
- **Arbitration** is combinational within the cycle.
  - Search `req_valid_i` starting at index `ptr` and wrapping modulo N.
  - The first set bit, index g, gets `req_ready_o[g]=1`. All other bits of `req_ready_o` are 0.
  - When no request is valid, `req_ready_o=0`.
- **Handshake** completes on a cycle with `req_valid_i[i] & req_ready_o[i]`.
  - The requester holds `req_valid_i` and its address stable until the handshake.
  - Deasserting valid before the grant is allowed; it withdraws the request.
- **Pointer update:** on a handshake with requester g, `ptr <= (g+1) mod N`. With no handshake, `ptr` holds. Reset value is 0.
- **ROM drive** is combinational and happens in the handshake cycle.
  - `rom_rd_en_o = |req_ready_o`.
  - `rom_rd_addr_o = req_addr_i[g]`.
  - When there is no grant, the address is `req_addr_i[ptr]`. It is don't-care, but must be deterministic.
- **In-flight tracking:** a tag pipeline of depth RL carries {valid, id}. When RL=0, the tag is consumed in the same cycle.
- **Response register:** when the tag reaches the ROM data stage, register on that edge:
  - `rsp_data_o <= rom_rd_data_i`
  - `rsp_id_o <= id`
  - `rsp_valid_o <= onehot(id)`
  - Otherwise `rsp_valid_o <= 0`, and `rsp_data_o`/`rsp_id_o` hold their last value.
- **Response backpressure:** none. Requesters must accept a response on the strobe cycle.
- **Throughput:** one grant per cycle sustained. Responses return in grant order.
- **busy_o** = any tag valid, OR any `rsp_valid_o` bit set.

## Timing
- A handshake in cycle T produces `rsp_valid_o[g]=1` in cycle T+1+RL, for exactly one cycle. That is T+2 when OUT_REG=1 and T+1 when OUT_REG=0.
- `req_ready_o` depends only on `req_valid_i` and `ptr`, with no combinational path from the ROM.
- Back-to-back grants in consecutive cycles produce responses in consecutive cycles.
- **Fairness:** with all N requesters continuously valid, each requester is granted exactly once every N cycles. A lone requester is granted every cycle.
- **Pointer wrap:** a grant to N-1 sets `ptr` to 0.
- **Reset values** (asynchronous, immediate):
  - `ptr=0` and all tags invalid.
  - `rsp_valid_o=0`, `rsp_id_o=0`, `rsp_data_o=0`, `busy_o=0`.
  - `req_ready_o` and `rom_rd_en_o` are 0 while `rst_i=1`; these combinational outputs are gated by reset.
- **Reset mid-operation:** in-flight reads are dropped, and no `rsp_valid_o` appears after reset release for requests granted before reset.
- **Simultaneous events:** a new grant and a response completing in the same cycle are independent and both occur.

## Test plan
- **Single request, OUT_REG=1:** requester 2 is valid with addr 5 in cycle T, and the ROM holds 0xA5 at 5 → `req_ready_o=4'b0100` and `rom_rd_en_o=1`/addr 5 in T; `rsp_valid_o=4'b0100`, `rsp_id_o=2`, `rsp_data_o=0xA5` in T+2 only.
- **Full contention:** all 4 requesters continuously valid from reset for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses arrive in the same order two cycles later, with data matching each address.
- **Lone streaming requester:** requester 3 is valid for 5 cycles with addrs 0..4, others idle → granted every cycle; 5 consecutive responses with ROM[0..4]; `ptr` ends at 0.
- **Pointer fairness after wrap:** requester 1 is granted, then requesters 0 and 1 are both valid → 0 is granted before 1.
- **Reset mid-flight:** assert `rst_i` one cycle after granting requester 1 → all outputs go to 0 immediately; no response appears after release; the next grant with all valid goes to requester 0.
- **OUT_REG=0 build:** a single grant in cycle T → response in T+1; 3 back-to-back grants → 3 consecutive responses.
